// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU-control decode and ID/EX stage
package alu_ctrl_pkg;

    localparam logic [1:0] ALU_OP_LDST   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // Low four bits keep the legacy ALU's encoding; bit [4] selects the mul/div unit
    localparam logic [4:0] CTRL_AND    = 5'b00000;
    localparam logic [4:0] CTRL_OR     = 5'b00001;
    localparam logic [4:0] CTRL_ADD    = 5'b00010;
    localparam logic [4:0] CTRL_XOR    = 5'b00011;
    localparam logic [4:0] CTRL_SLL    = 5'b00100;
    localparam logic [4:0] CTRL_SRL    = 5'b00101;
    localparam logic [4:0] CTRL_SUB    = 5'b00110;
    localparam logic [4:0] CTRL_SRA    = 5'b00111;
    localparam logic [4:0] CTRL_SLT    = 5'b01000;
    localparam logic [4:0] CTRL_SLTU   = 5'b01001;
    localparam logic [4:0] CTRL_MUL    = 5'b10000;
    localparam logic [4:0] CTRL_MULH   = 5'b10001;
    localparam logic [4:0] CTRL_MULHSU = 5'b10010;
    localparam logic [4:0] CTRL_MULHU  = 5'b10011;
    localparam logic [4:0] CTRL_DIV    = 5'b10100;
    localparam logic [4:0] CTRL_DIVU   = 5'b10101;
    localparam logic [4:0] CTRL_REM    = 5'b10110;
    localparam logic [4:0] CTRL_REMU   = 5'b10111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        LC_SINGLE = 2'd0,
        LC_MUL    = 2'd1,
        LC_DIV    = 2'd2
    } lat_class_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALU_Op/funct3/funct7 to ALU control decode
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] ctrl,
    output logic       illegal,
    output lat_class_e lat_class
);

    always_comb begin
        ctrl      = CTRL_ADD;
        illegal   = 1'b0;
        lat_class = LC_SINGLE;
        case (alu_op)
            ALU_OP_LDST: ctrl = CTRL_ADD;
            ALU_OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl = CTRL_SUB;
                    3'b100, 3'b101: ctrl = CTRL_SLT;
                    3'b110, 3'b111: ctrl = CTRL_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            ALU_OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl = CTRL_ADD;
                        3'b001:  ctrl = CTRL_SLL;
                        3'b010:  ctrl = CTRL_SLT;
                        3'b011:  ctrl = CTRL_SLTU;
                        3'b100:  ctrl = CTRL_XOR;
                        3'b101:  ctrl = CTRL_SRL;
                        3'b110:  ctrl = CTRL_OR;
                        default: ctrl = CTRL_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      ctrl = CTRL_SUB;
                    else if (funct3 == 3'b101) ctrl = CTRL_SRA;
                    else                       illegal = 1'b1;
                end else if (EN_M && (funct7 == F7_MULDIV)) begin
                    // funct3 maps straight onto the low bits; funct3[2] splits mul from div/rem
                    ctrl      = {2'b10, funct3};
                    lat_class = funct3[2] ? LC_DIV : LC_MUL;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                case (funct3)
                    3'b000: ctrl = CTRL_ADD;
                    3'b010: ctrl = CTRL_SLT;
                    3'b011: ctrl = CTRL_SLTU;
                    3'b100: ctrl = CTRL_XOR;
                    3'b110: ctrl = CTRL_OR;
                    3'b111: ctrl = CTRL_AND;
                    3'b001: begin
                        if (funct7 == F7_BASE) ctrl = CTRL_SLL;
                        else                   illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     ctrl = CTRL_SRL;
                        else if (funct7 == F7_ALT) ctrl = CTRL_SRA;
                        else                       illegal = 1'b1;
                    end
                endcase
            end
        endcase
        if (illegal) begin
            ctrl      = CTRL_ADD;
            lat_class = LC_SINGLE;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ID/EX register for ALU control with valid/ready and mul/div hold
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              mc_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [4:0]       dec_ctrl;
    logic             dec_illegal;
    lat_class_e       dec_lat;
    logic [4:0]       ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             in_fire;
    logic             out_fire;

    alu_ctrl_decode #(
        .EN_M (EN_M)
    ) u_decode (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .ctrl      (dec_ctrl),
        .illegal   (dec_illegal),
        .lat_class (dec_lat)
    );

    assign out_fire = out_valid & out_ready & (cnt == '0);
    assign in_ready = !rst & !flush & (!out_valid | out_fire);
    assign in_fire  = in_valid & in_ready;
    assign mc_busy  = out_valid & (cnt != '0);
    assign alu_ctrl = CTRL_W'(ctrl_q);
    assign illegal  = illegal_q;

    always_comb begin
        cnt_load = '0;
        case (dec_lat)
            LC_MUL:  cnt_load = CNT_W'(MUL_LAT - 1);
            LC_DIV:  cnt_load = CNT_W'(DIV_LAT - 1);
            default: cnt_load = '0;
        endcase
    end

    // The counter runs regardless of out_ready so EX sees a fixed minimum occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= CTRL_ADD;
            illegal_q <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            cnt       <= cnt_load;
        end else begin
            if (out_fire) out_valid <= 1'b0;
            if (out_valid && (cnt != '0)) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    typedef struct {
        logic [4:0] ctrl;
        logic       ill;
        int         lat;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, illegal, mc_busy;
    logic [4:0] alu_ctrl;
    logic       in_ready0, out_valid0, illegal0, mc_busy0;
    logic [4:0] alu_ctrl0;

    int total = 0;
    int bad = 0;
    int busy0_seen = 0;

    always #5 clk = ~clk;

    alu_ctrl_stage #(.CTRL_W(5), .EN_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctrl(alu_ctrl), .illegal(illegal), .mc_busy(mc_busy)
    );

    alu_ctrl_stage #(.CTRL_W(5), .EN_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid0),
        .out_ready(out_ready), .alu_ctrl(alu_ctrl0), .illegal(illegal0), .mc_busy(mc_busy0)
    );

    // Reference decode built from the instruction tables
    function automatic dec_t ref_dec(input bit en_m, input logic [1:0] op,
                                     input logic [2:0] f3, input logic [6:0] f7);
        logic [4:0] br_tab [8] = '{5'd6, 5'd6, 5'd2, 5'd2, 5'd8, 5'd8, 5'd9, 5'd9};
        bit         br_ok  [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic [4:0] r_tab  [8] = '{5'd2, 5'd4, 5'd8, 5'd9, 5'd3, 5'd5, 5'd1, 5'd0};
        dec_t d;
        d.ctrl = 5'd2;
        d.ill  = 1'b0;
        d.lat  = 1;
        if (op == 2'd1) begin
            d.ctrl = br_tab[f3];
            d.ill  = !br_ok[f3];
        end else if (op == 2'd2) begin
            if (f7 == 7'h00) d.ctrl = r_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) d.ctrl = 5'd6;
            else if (f7 == 7'h20 && f3 == 3'd5) d.ctrl = 5'd7;
            else if (f7 == 7'h01 && en_m) begin
                d.ctrl = 5'd16 + 5'(f3);
                d.lat  = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
            end else d.ill = 1'b1;
        end else if (op == 2'd3) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) d.ctrl = 5'd4;
                else d.ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) d.ctrl = 5'd5;
                else if (f7 == 7'h20) d.ctrl = 5'd7;
                else d.ill = 1'b1;
            end else d.ctrl = r_tab[f3];
        end
        if (d.ill) d.ctrl = 5'd2;
        return d;
    endfunction

    task automatic tick(input bit r, input bit fl, input bit iv, input logic [1:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input bit ordy);
        @(negedge clk);
        rst = r; flush = fl; in_valid = iv; alu_op = op;
        funct3 = f3; funct7 = f7; out_ready = ordy;
        #1;
        if (mc_busy0) busy0_seen++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 1, 2'd2, 3'd0, 7'h00, 1);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
            total++; if (alu_ctrl !== 5'b00010) begin bad++; $display("FAIL reset_ctrl got %b want 00010", alu_ctrl); end
            total++; if (illegal !== 1'b0 || mc_busy !== 1'b0) begin bad++; $display("FAIL reset_flags got ill=%b busy=%b want 0/0", illegal, mc_busy); end
        end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [2:0] f3s [5] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd5};
        logic [6:0] f7s [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h20};
        logic [4:0] exp [5] = '{5'b00010, 5'b00110, 5'b00000, 5'b00001, 5'b00111};
        tick(0, 0, 1, 2'd2, f3s[0], f7s[0], 1);
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) tick(0, 0, 1, 2'd2, f3s[k], f7s[k], 1);
            else       tick(0, 0, 1, 2'd2, 3'd0, 7'h00, 0);
            total++;
            if (out_valid !== 1'b1 || alu_ctrl !== exp[k-1])
                begin bad++; $display("FAIL stream_op%0d got v=%b ctrl=%b want v=1 ctrl=%b", k-1, out_valid, alu_ctrl, exp[k-1]); end
        end
        for (int h = 0; h < 3; h++) begin
            if (h > 0) tick(0, 0, 1, 2'd2, 3'd0, 7'h00, 0);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_ctrl !== 5'b00111)
                begin bad++; $display("FAIL stream_hold%0d got rdy=%b v=%b ctrl=%b want 0/1/00111", h, in_ready, out_valid, alu_ctrl); end
        end
        tick(0, 0, 1, 2'd2, 3'd0, 7'h00, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_release_rdy got %b want 1", in_ready); end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++; if (out_valid !== 1'b1 || alu_ctrl !== 5'b00010) begin bad++; $display("FAIL stream_after_hold got v=%b ctrl=%b want 1/00010", out_valid, alu_ctrl); end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_itype();
        logic [1:0] ops [6] = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0};
        logic [2:0] f3s [6] = '{3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd5};
        logic [6:0] f7s [6] = '{7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h33};
        logic [4:0] ec  [6] = '{5'b00010, 5'b00111, 5'b00010, 5'b01001, 5'b00010, 5'b00010};
        logic       ei  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 1, ops[i], f3s[i], f7s[i], 1);
            tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
            total++;
            if (out_valid !== 1'b1 || alu_ctrl !== ec[i] || illegal !== ei[i])
                begin bad++; $display("FAIL itype_%0d got v=%b ctrl=%b ill=%b want 1/%b/%b", i, out_valid, alu_ctrl, illegal, ec[i], ei[i]); end
        end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
    endtask

    task automatic test_multicycle();
        int busy;
        tick(0, 0, 1, 2'd2, 3'd4, 7'h01, 1);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 1, 2'd2, 3'd0, 7'h00, 1);
            if (mc_busy !== 1'b1) break;
            busy++;
            total++;
            if (in_ready !== 1'b0 || alu_ctrl !== 5'b10100)
                begin bad++; $display("FAIL div_busy_c%0d got rdy=%b ctrl=%b want 0/10100", busy, in_ready, alu_ctrl); end
        end
        total++; if (busy != DIV_LAT - 1) begin bad++; $display("FAIL div_busy_cycles got %0d want %0d", busy, DIV_LAT - 1); end
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_ctrl !== 5'b10100)
            begin bad++; $display("FAIL div_fire got v=%b rdy=%b ctrl=%b want 1/1/10100", out_valid, in_ready, alu_ctrl); end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++; if (out_valid !== 1'b1 || alu_ctrl !== 5'b00010) begin bad++; $display("FAIL div_next got v=%b ctrl=%b want 1/00010", out_valid, alu_ctrl); end
        tick(0, 0, 1, 2'd2, 3'd0, 7'h01, 1);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
            if (mc_busy !== 1'b1) break;
            busy++;
        end
        total++; if (busy != MUL_LAT - 1) begin bad++; $display("FAIL mul_busy_cycles got %0d want %0d", busy, MUL_LAT - 1); end
        total++; if (out_valid !== 1'b1 || alu_ctrl !== 5'b10000) begin bad++; $display("FAIL mul_fire got v=%b ctrl=%b want 1/10000", out_valid, alu_ctrl); end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
    endtask

    task automatic test_flush();
        tick(0, 0, 1, 2'd2, 3'd4, 7'h01, 1);
        for (int c = 1; c < 10; c++) tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        tick(0, 1, 1, 2'd2, 3'd0, 7'h00, 1);
        total++; if (in_ready !== 1'b0 || mc_busy !== 1'b1) begin bad++; $display("FAIL flush_cycle got rdy=%b busy=%b want 0/1", in_ready, mc_busy); end
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++;
        if (out_valid !== 1'b0 || mc_busy !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_after got v=%b busy=%b rdy=%b want 0/0/1", out_valid, mc_busy, in_ready); end
    endtask

    task automatic test_en_m0();
        tick(0, 0, 1, 2'd2, 3'd4, 7'h01, 1);
        tick(0, 0, 0, 2'd0, 3'd0, 7'h00, 1);
        total++;
        if (out_valid0 !== 1'b1 || illegal0 !== 1'b1 || alu_ctrl0 !== 5'b00010 || mc_busy0 !== 1'b0)
            begin bad++; $display("FAIL enm0_div got v=%b ill=%b ctrl=%b busy=%b want 1/1/00010/0", out_valid0, illegal0, alu_ctrl0, mc_busy0); end
        tick(0, 1, 0, 2'd0, 3'd0, 7'h00, 1);
    endtask

    task automatic test_random();
        dec_t q[$];
        int   age = 0;
        bit   iv, ordy, fl, e_ov, e_busy, e_ofire, e_rdy;
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [6:0] f7_pick [3] = '{7'h00, 7'h20, 7'h01};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 99) < 2);
            op   = 2'($urandom);
            f3   = 3'($urandom);
            f7   = ($urandom_range(0, 3) == 3) ? 7'($urandom) : f7_pick[$urandom_range(0, 2)];
            tick(0, fl, iv, op, f3, f7, ordy);
            e_ov    = (q.size() > 0);
            e_busy  = e_ov && (age < q[0].lat - 1);
            e_ofire = e_ov && ordy && !e_busy;
            e_rdy   = !fl && (!e_ov || e_ofire);
            total++;
            if (out_valid !== e_ov || mc_busy !== e_busy || in_ready !== e_rdy)
                begin bad++; $display("FAIL rand_hs c%0d got v=%b busy=%b rdy=%b want %b/%b/%b", cyc, out_valid, mc_busy, in_ready, e_ov, e_busy, e_rdy); end
            if (e_ov) begin
                total++;
                if (alu_ctrl !== q[0].ctrl || illegal !== q[0].ill)
                    begin bad++; $display("FAIL rand_data c%0d got ctrl=%b ill=%b want %b/%b", cyc, alu_ctrl, illegal, q[0].ctrl, q[0].ill); end
            end
            if (fl) q.delete();
            else begin
                if (e_ofire) void'(q.pop_front());
                else if (e_ov) age++;
                if (iv && e_rdy) begin
                    q.push_back(ref_dec(1'b1, op, f3, f7));
                    age = 0;
                end
            end
        end
        total++; if (busy0_seen != 0) begin bad++; $display("FAIL enm0_never_busy got %0d busy cycles want 0", busy0_seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_itype();
        test_multicycle();
        test_flush();
        test_en_m0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Parametrised ALU-control decode plus ID/EX register stage for the pipelined RV32I core.
- Decodes ALU_Op/funct3/funct7 to the full RV32I ALU op set, with optional M-extension.
- Decodes branch-compare variants.
- Registers the result behind a valid/ready handshake.
- Holds multi-cycle MUL/DIV ops in the register for a programmable latency, back-pressuring upstream via mc_busy.
- Sits between the main control unit (ID) and the ALU / mul-div unit (EX).

Parameters:
CTRL_W, 5, ALU control width; must be >= 5; bits above [4] are driven 0.
EN_M, 1, 1 = decode M-extension ops; 0 = treat funct7=0000001 in R-type as illegal.
MUL_LAT, 2, cycles a MUL-class op occupies the output register; >= 1.
DIV_LAT, 32, cycles a DIV/REM-class op occupies the output register; >= 1.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush  in  1  synchronous pipeline flush (branch mispredict / trap)
in_valid  in  1  decode fields valid
in_ready  out  1  stage accepts input this cycle
alu_op  in  2  00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7 (I-type: imm[11:5])
out_valid  out  1  registered op valid
out_ready  in  1  EX accepts op
alu_ctrl  out  CTRL_W  registered ALU control
illegal  out  1  registered illegal-encoding flag
mc_busy  out  1  multi-cycle op still counting

Behaviour:
Control encodings (low four match the legacy ALU):
- AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111, SLT 01000, SLTU 01001.
- MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.

Decode:
- alu_op 00: ADD.
- alu_op 01 (branch), by funct3: 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
- alu_op 10, funct7=0000000, funct3 000..111 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- alu_op 10, funct7=0100000: funct3 000 -> SUB; 101 -> SRA; else illegal.
- alu_op 10, funct7=0000001 with EN_M=1: funct3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. With EN_M=0: illegal.
- alu_op 10, any other funct7: illegal.
- alu_op 11, funct3 000/010/011/100/110/111 -> ADD/SLT/SLTU/XOR/OR/AND; funct7 ignored (immediate bits).
- alu_op 11, funct3 001: SLL only if funct7=0000000, else illegal.
- alu_op 11, funct3 101: funct7=0000000 -> SRL; 0100000 -> SRA; else illegal.
- Any illegal encoding: alu_ctrl=ADD, illegal=1, single-cycle class.

Handshake:
- out_fire = out_valid & out_ready & (cnt==0).
- in_ready = !rst & !flush & (!out_valid | out_fire), combinational.
- in_fire = in_valid & in_ready: next cycle out_valid=1 and decode registered (latency 1).
- out_fire without in_fire: out_valid <= 0.
- Simultaneous in_fire and out_fire: register reloads; throughput 1 op/cycle for single-cycle ops.
- alu_ctrl and illegal are held stable while out_valid & !out_fire.

Multi-cycle counter:
- cnt width = clog2(max(MUL_LAT, DIV_LAT)+1).
- On in_fire of a MUL-class op: cnt <= MUL_LAT-1. DIV/REM-class: cnt <= DIV_LAT-1. Otherwise cnt <= 0.
- While out_valid & cnt!=0, cnt decrements every cycle, independent of out_ready.
- mc_busy = out_valid & (cnt!=0).
- An op therefore occupies the register for at least LAT cycles. LAT=1 behaves as single-cycle.

Flush:
- Next cycle: out_valid=0, cnt=0, mc_busy=0.
- in_ready=0 during the flush cycle; any input offered that cycle is dropped.
- Flush aborts an in-progress DIV.

Reset:
- out_valid=0, alu_ctrl=ADD (00010), illegal=0, cnt=0, mc_busy=0.
- in_ready=0 while rst=1.
- Reset mid-DIV aborts identically to flush.

Decomposition:
- Package alu_ctrl_pkg holds: ALU_Op encodings, all control encodings, funct7 constants (F7_BASE, F7_ALT, F7_MULDIV), latency-class enum (LC_SINGLE, LC_MUL, LC_DIV).
- Sub-module alu_ctrl_decode: pure combinational decode, outputs {ctrl, illegal, lat_class}.
- alu_ctrl_stage owns the register, handshake and counter.

Test Plan:
- Reset: assert rst 2 cycles, in_valid=1 -> in_ready=0, out_valid=0, alu_ctrl=00010. After release, in_ready=1.
- Stream ADD, SUB(f7=0100000), AND, OR, SRA with out_ready=1 -> out_valid every cycle from cycle 1, ctrl 00010, 00110, 00000, 00001, 00111, no bubbles. Drop out_ready for 3 cycles -> output held, in_ready=0.
- I-type: addi f7=0100000 -> ADD (00010), not SUB. srai f7=0100000 -> 00111. slli f7=0100000 -> illegal=1, ctrl=00010. Branch f3=110 -> 01001. Branch f3=010 -> illegal.
- DIV (f7=0000001, f3=100), DIV_LAT=32, out_ready=1 -> mc_busy=1 for 31 cycles, in_ready=0, out_fire on the 32nd cycle after load. MUL with MUL_LAT=2 -> exactly 1 busy cycle.
- Flush on cycle 10 of a DIV with in_valid=1 -> next cycle out_valid=0, mc_busy=0; flushed-cycle input not captured; following cycle in_ready=1.
- EN_M=0: R-type f7=0000001 f3=100 -> illegal=1, ctrl=00010, mc_busy never asserted.
